// File: rtl/genel_denetim_birimi_if.sv
// Pipeline control bus: fetch/decode/execute handshakes, forwarding sources and performance counters.
interface genel_denetim_birimi_if #(
    parameter int KAYNAK_SAYISI = 3,
    parameter int ADRES_BIT     = 5,
    parameter int SAYAC_BIT     = 32
);
    localparam int S = $clog2(KAYNAK_SAYISI + 1);

    logic                               gtr_yanlis_tahmin_i;
    logic                               gtr_hazir_i;
    logic                               gtr_durdur_o;
    logic                               gtr_bosalt_o;
    logic                               cyo_gecerli_i;
    logic [ADRES_BIT-1:0]               cyo_rs1_adres_i;
    logic [ADRES_BIT-1:0]               cyo_rs2_adres_i;
    logic [S-1:0]                       cyo_yonlendir_kontrol1_o;
    logic [S-1:0]                       cyo_yonlendir_kontrol2_o;
    logic                               cyo_durdur_o;
    logic                               cyo_bosalt_o;
    logic [KAYNAK_SAYISI-1:0]           kaynak_yaz_i;
    logic [KAYNAK_SAYISI*ADRES_BIT-1:0] kaynak_rd_adres_i;
    logic [KAYNAK_SAYISI-1:0]           kaynak_veri_hazir_i;
    logic                               yrt_hazir_i;
    logic                               yrt_durdur_o;
    logic                               yrt_kabarcik_o;
    logic                               hazir_o;
    logic [SAYAC_BIT-1:0]               durma_sayaci_o;
    logic [SAYAC_BIT-1:0]               bosaltma_sayaci_o;

    modport master (
        output gtr_yanlis_tahmin_i, gtr_hazir_i, cyo_gecerli_i, cyo_rs1_adres_i, cyo_rs2_adres_i,
               kaynak_yaz_i, kaynak_rd_adres_i, kaynak_veri_hazir_i, yrt_hazir_i,
        input  gtr_durdur_o, gtr_bosalt_o, cyo_yonlendir_kontrol1_o, cyo_yonlendir_kontrol2_o,
               cyo_durdur_o, cyo_bosalt_o, yrt_durdur_o, yrt_kabarcik_o, hazir_o,
               durma_sayaci_o, bosaltma_sayaci_o
    );

    modport slave (
        input  gtr_yanlis_tahmin_i, gtr_hazir_i, cyo_gecerli_i, cyo_rs1_adres_i, cyo_rs2_adres_i,
               kaynak_yaz_i, kaynak_rd_adres_i, kaynak_veri_hazir_i, yrt_hazir_i,
        output gtr_durdur_o, gtr_bosalt_o, cyo_yonlendir_kontrol1_o, cyo_yonlendir_kontrol2_o,
               cyo_durdur_o, cyo_bosalt_o, yrt_durdur_o, yrt_kabarcik_o, hazir_o,
               durma_sayaci_o, bosaltma_sayaci_o
    );
endinterface

// File: rtl/genel_denetim_birimi.sv
// Pipeline hazard/control unit: startup hold, priority operand forwarding,
// load-use stalls, misprediction flushes and saturating stall/flush counters.
module genel_denetim_birimi #(
    parameter int KAYNAK_SAYISI    = 3,
    parameter int ADRES_BIT        = 5,
    parameter int BASLANGIC_CEVRIM = 256,
    parameter int BOSALTMA_CEVRIM  = 1,
    parameter int SAYAC_BIT        = 32
) (
    input logic                   clk_i,
    input logic                   rst_i,
    genel_denetim_birimi_if.slave bus
);
    localparam int S = $clog2(KAYNAK_SAYISI + 1);
    localparam logic [15:0] BASLAT_SON = 16'(BASLANGIC_CEVRIM - 1);
    localparam logic [3:0]  BOSALT_YUK = 4'(BOSALTMA_CEVRIM - 1);

    typedef enum logic [1:0] {
        BASLAT,
        CALIS,
        BOSALT
    } durum_e;

    durum_e               durum_q, durum_d;
    logic [15:0]          baslat_sayac_q, baslat_sayac_d;
    logic [3:0]           bosalt_sayac_q, bosalt_sayac_d;
    logic [SAYAC_BIT-1:0] durma_sayac_q, durma_sayac_d;
    logic [SAYAC_BIT-1:0] bosaltma_sayac_q, bosaltma_sayac_d;

    logic [S-1:0] kontrol1, kontrol2;
    logic         bekle1, bekle2;
    logic         baslatta, bosalt, tehlike, durdur;

    // Scanning from the oldest source down lets the youngest match overwrite older ones.
    function automatic void kaynak_sec(
        input  logic [ADRES_BIT-1:0]               rs,
        input  logic [KAYNAK_SAYISI-1:0]           yaz,
        input  logic [KAYNAK_SAYISI*ADRES_BIT-1:0] rd,
        input  logic [KAYNAK_SAYISI-1:0]           veri_hazir,
        output logic [S-1:0]                       kontrol,
        output logic                               bekle
    );
        kontrol = '0;
        bekle   = 1'b0;
        for (int k = KAYNAK_SAYISI - 1; k >= 0; k--) begin
            if (yaz[k] && (rd[k*ADRES_BIT +: ADRES_BIT] == rs) && (rs != '0)) begin
                kontrol = veri_hazir[k] ? S'(k + 1) : '0;
                bekle   = ~veri_hazir[k];
            end
        end
    endfunction

    always_comb begin
        kaynak_sec(bus.cyo_rs1_adres_i, bus.kaynak_yaz_i, bus.kaynak_rd_adres_i,
                   bus.kaynak_veri_hazir_i, kontrol1, bekle1);
        kaynak_sec(bus.cyo_rs2_adres_i, bus.kaynak_yaz_i, bus.kaynak_rd_adres_i,
                   bus.kaynak_veri_hazir_i, kontrol2, bekle2);
    end

    // A flush squashes the decode instruction, so it masks any hazard stall.
    always_comb begin
        baslatta = (durum_q == BASLAT);
        bosalt   = (durum_q != CALIS) | bus.gtr_yanlis_tahmin_i;
        tehlike  = bus.cyo_gecerli_i & ~bosalt & (bekle1 | bekle2);
        durdur   = baslatta | ~bus.yrt_hazir_i | ~bus.gtr_hazir_i | tehlike;
    end

    always_comb begin
        durum_d          = durum_q;
        baslat_sayac_d   = baslat_sayac_q;
        bosalt_sayac_d   = bosalt_sayac_q;
        durma_sayac_d    = durma_sayac_q;
        bosaltma_sayac_d = bosaltma_sayac_q;

        case (durum_q)
            BASLAT: begin
                baslat_sayac_d = baslat_sayac_q + 16'd1;
                if (baslat_sayac_q == BASLAT_SON) begin
                    durum_d = CALIS;
                end
            end
            CALIS: begin
                if (bus.gtr_yanlis_tahmin_i) begin
                    durum_d        = BOSALT;
                    bosalt_sayac_d = BOSALT_YUK;
                end
            end
            BOSALT: begin
                if (bus.gtr_yanlis_tahmin_i) begin
                    bosalt_sayac_d = BOSALT_YUK;
                end else if (bosalt_sayac_q == 4'd0) begin
                    durum_d = CALIS;
                end else begin
                    bosalt_sayac_d = bosalt_sayac_q - 4'd1;
                end
            end
            default: durum_d = BASLAT;
        endcase

        if (!baslatta && durdur && (durma_sayac_q != '1)) begin
            durma_sayac_d = durma_sayac_q + 1'b1;
        end
        if (!baslatta && bus.gtr_yanlis_tahmin_i && (bosaltma_sayac_q != '1)) begin
            bosaltma_sayac_d = bosaltma_sayac_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum_q          <= BASLAT;
            baslat_sayac_q   <= '0;
            bosalt_sayac_q   <= '0;
            durma_sayac_q    <= '0;
            bosaltma_sayac_q <= '0;
        end else begin
            durum_q          <= durum_d;
            baslat_sayac_q   <= baslat_sayac_d;
            bosalt_sayac_q   <= bosalt_sayac_d;
            durma_sayac_q    <= durma_sayac_d;
            bosaltma_sayac_q <= bosaltma_sayac_d;
        end
    end

    assign bus.gtr_durdur_o             = durdur;
    assign bus.cyo_durdur_o             = durdur;
    assign bus.gtr_bosalt_o             = bosalt;
    assign bus.cyo_bosalt_o             = bosalt;
    assign bus.yrt_durdur_o             = baslatta | ~bus.gtr_hazir_i;
    assign bus.yrt_kabarcik_o           = tehlike & bus.yrt_hazir_i & bus.gtr_hazir_i;
    assign bus.hazir_o                  = ~baslatta;
    assign bus.cyo_yonlendir_kontrol1_o = kontrol1;
    assign bus.cyo_yonlendir_kontrol2_o = kontrol2;
    assign bus.durma_sayaci_o           = durma_sayac_q;
    assign bus.bosaltma_sayaci_o        = bosaltma_sayac_q;
endmodule
